// File: rtl/fft_comm_pkg.sv
// Shared constants and lane-pair mapping for the 4-lane FFT commutators.
package fft_comm_pkg;

  localparam int NUM_LANES  = 4;
  localparam int NUM_PAIRS  = NUM_LANES / 2;
  localparam int PAIR_ADJ   = 0;
  localparam int PAIR_SPLIT = 1;

  // Lower lane of a pair: delayed on the input side.
  function automatic int lane_a(int pair, int pairing);
    return (pairing == PAIR_SPLIT) ? pair : 2 * pair;
  endfunction

  // Upper lane of a pair: delayed on the output side.
  function automatic int lane_b(int pair, int pairing);
    return (pairing == PAIR_SPLIT) ? pair + NUM_PAIRS : 2 * pair + 1;
  endfunction

endpackage

// File: rtl/delay_line_en.sv
// NB-wide, DEPTH-deep shift register; advances only when en is high.
module delay_line_en #(
  parameter int NB    = 16,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [NB-1:0] d,
  output logic [NB-1:0] q
);

  logic [NB-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: storage is a flop chain, so clearing every stage on reset is cheap and
      // keeps stale samples from a previous run out of the first frame.
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments let every stage shift by exactly one per beat.
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/commutator_gen.sv
// 4-lane delay-switch-delay commutator: lane a delayed D beats, 2x2 swap on sel,
// lane b delayed D beats; beat counter, priming, bypass latch and output registers.
module commutator_gen
  import fft_comm_pkg::*;
#(
  parameter int NB      = 16,
  parameter int LOG2D   = 0,
  parameter int PAIRING = PAIR_ADJ
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    start,
  input  logic                    bypass,
  input  logic [NUM_LANES*NB-1:0] in_data,
  output logic                    out_valid,
  output logic                    out_start,
  output logic [NUM_LANES*NB-1:0] out_data
);

  localparam int D  = 1 << LOG2D;
  localparam int NW = LOG2D + 1;
  localparam int PW = LOG2D + 2;

  logic [NW-1:0]           n_q, n_d, n_cur;
  logic [PW-1:0]           prime_q, prime_d, prime_cur;
  logic                    active_q, active_d, bypass_q, bypass_d;
  logic                    out_valid_q, out_valid_d, out_start_q, out_start_d;
  logic [NUM_LANES*NB-1:0] out_data_q, out_data_d, y_word;
  logic                    start_beat, act_cur, byp_cur, sel;
  logic [NB-1:0]           y_a [NUM_PAIRS];
  logic [NB-1:0]           y_b [NUM_PAIRS];

  // The start beat itself is n=0 and already uses the bypass value sampled with it.
  always_comb begin
    start_beat = in_valid & start;
    n_cur      = start_beat ? '0 : n_q;
    prime_cur  = start_beat ? '0 : prime_q;
    act_cur    = start_beat | active_q;
    byp_cur    = start_beat ? bypass : bypass_q;
    sel        = n_cur[LOG2D] & ~byp_cur;
  end

  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
    localparam int LA = lane_a(p, PAIRING);
    localparam int LB = lane_b(p, PAIRING);
    logic [NB-1:0] x_a, x_b, x_a_dly, z_b;

    assign x_a = in_data[LA*NB +: NB];
    assign x_b = in_data[LB*NB +: NB];

    delay_line_en #(.NB(NB), .DEPTH(D)) u_dly_in (
      .clk(clk), .reset(reset), .en(in_valid), .d(x_a), .q(x_a_dly)
    );

    assign y_a[p] = sel ? x_b : x_a_dly;
    assign z_b    = sel ? x_a_dly : x_b;

    delay_line_en #(.NB(NB), .DEPTH(D)) u_dly_out (
      .clk(clk), .reset(reset), .en(in_valid), .d(z_b), .q(y_b[p])
    );
  end

  always_comb begin
    y_word = '0;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      y_word[lane_a(p, PAIRING)*NB +: NB] = y_a[p];
      y_word[lane_b(p, PAIRING)*NB +: NB] = y_b[p];
    end
  end

  // Priming count saturates at D+1 so "== D" marks only the first valid output.
  always_comb begin
    // NOTE: defaults first; every path assigns every variable, so no latches appear.
    n_d         = n_q;
    prime_d     = prime_q;
    active_d    = active_q;
    bypass_d    = bypass_q;
    out_valid_d = 1'b0;
    out_start_d = 1'b0;
    out_data_d  = out_data_q;
    if (in_valid) begin
      n_d         = n_cur + NW'(1);
      prime_d     = (prime_cur > PW'(D)) ? prime_cur : prime_cur + PW'(1);
      active_d    = act_cur;
      bypass_d    = byp_cur;
      out_valid_d = act_cur & (prime_cur >= PW'(D));
      out_start_d = act_cur & (prime_cur == PW'(D));
      out_data_d  = y_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q         <= '0;
      prime_q     <= '0;
      active_q    <= 1'b0;
      bypass_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      n_q         <= n_d;
      prime_q     <= prime_d;
      active_q    <= active_d;
      bypass_q    <= bypass_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_start = out_start_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_commutator_gen.sv
// Self-checking bench: four commutator configurations share one stimulus stream and
// are compared against a beat-history model of the switch equations.
module tb_commutator_gen;

  localparam int NB   = 16;
  localparam int W    = 4 * NB;
  localparam int NCFG = 4;
  localparam int HMAX = 2048;

  int cfg_lg [NCFG] = '{0, 2, 1, 0};
  int cfg_pr [NCFG] = '{0, 0, 0, 1};
  int pair_a [2][2] = '{'{0, 2}, '{0, 1}};
  int pair_b [2][2] = '{'{1, 3}, '{2, 3}};

  logic         clk = 1'b0;
  logic         reset, in_valid, start, bypass;
  logic [W-1:0] in_data;
  logic         ov [NCFG];
  logic         os [NCFG];
  logic [W-1:0] od [NCFG];

  commutator_gen #(.NB(NB), .LOG2D(0), .PAIRING(0)) dut_d1 (.clk(clk), .reset(reset), .in_valid(in_valid), .start(start), .bypass(bypass), .in_data(in_data), .out_valid(ov[0]), .out_start(os[0]), .out_data(od[0]));
  commutator_gen #(.NB(NB), .LOG2D(2), .PAIRING(0)) dut_d4 (.clk(clk), .reset(reset), .in_valid(in_valid), .start(start), .bypass(bypass), .in_data(in_data), .out_valid(ov[1]), .out_start(os[1]), .out_data(od[1]));
  commutator_gen #(.NB(NB), .LOG2D(1), .PAIRING(0)) dut_d2 (.clk(clk), .reset(reset), .in_valid(in_valid), .start(start), .bypass(bypass), .in_data(in_data), .out_valid(ov[2]), .out_start(os[2]), .out_data(od[2]));
  commutator_gen #(.NB(NB), .LOG2D(0), .PAIRING(1)) dut_sp (.clk(clk), .reset(reset), .in_valid(in_valid), .start(start), .bypass(bypass), .in_data(in_data), .out_valid(ov[3]), .out_start(os[3]), .out_data(od[3]));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: history of valid input words and the sel used on each beat.
  logic [W-1:0] hx [HMAX];
  bit           hs [NCFG][HMAX];
  int           t;
  int           m_n [NCFG];
  int           m_prime [NCFG];
  bit           m_act [NCFG];
  bit           m_byp [NCFG];
  logic         exp_v [NCFG];
  logic         exp_s [NCFG];
  logic [W-1:0] exp_d [NCFG];
  bit           exp_known [NCFG];

  function automatic logic [NB-1:0] lane(logic [W-1:0] w, int k);
    return w[k*NB +: NB];
  endfunction

  function automatic logic [W-1:0] hist(int i);
    return (i < 0) ? '0 : hx[i];
  endfunction

  function automatic logic [W-1:0] mk_word(int a, int b);
    return {NB'(b + 100), NB'(a + 100), NB'(b), NB'(a)};
  endfunction

  task automatic model_reset();
    t = 0;
    for (int c = 0; c < NCFG; c++) begin
      m_n[c] = 0; m_prime[c] = 0; m_act[c] = 0; m_byp[c] = 0;
      exp_v[c] = 0; exp_s[c] = 0; exp_d[c] = '0; exp_known[c] = 1;
    end
  endtask

  task automatic model_beat(input logic v, input logic s, input logic b, input logic [W-1:0] d);
    if (!v) begin
      for (int c = 0; c < NCFG; c++) begin exp_v[c] = 0; exp_s[c] = 0; end
      return;
    end
    if (t >= HMAX) begin
      $display("FAIL model_history: beat count %0d exceeds %0d", t, HMAX);
      $fatal(1);
    end
    hx[t] = d;
    for (int c = 0; c < NCFG; c++) begin
      int dd, a, bl;
      bit sel;
      logic [W-1:0] y;
      dd = 1 << cfg_lg[c];
      y  = '0;
      if (s) begin m_act[c] = 1; m_n[c] = 0; m_prime[c] = 0; m_byp[c] = b; end
      sel = !m_byp[c] && (m_n[c] >= dd);
      hs[c][t] = sel;
      for (int p = 0; p < 2; p++) begin
        a  = pair_a[cfg_pr[c]][p];
        bl = pair_b[cfg_pr[c]][p];
        y[a*NB +: NB]  = sel ? lane(d, bl) : lane(hist(t - dd), a);
        y[bl*NB +: NB] = (t - dd >= 0 && hs[c][t - dd]) ? lane(hist(t - 2*dd), a)
                                                          : lane(hist(t - dd), bl);
      end
      exp_v[c] = m_act[c] && (m_prime[c] >= dd);
      exp_s[c] = m_act[c] && (m_prime[c] == dd);
      exp_known[c] = exp_v[c];
      if (exp_v[c]) exp_d[c] = y;
      m_n[c] = (m_n[c] + 1) % (2 * dd);
      if (m_prime[c] <= dd) m_prime[c]++;
    end
    t++;
  endtask

  task automatic step(input logic v, input logic s, input logic b, input logic [W-1:0] d);
    @(negedge clk);
    in_valid = v; start = s; bypass = b; in_data = d;
    model_beat(v, s, b, d);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; start = 1'b0; bypass = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < NCFG; c++) begin
      n_cmp++;
      if (ov[c] !== 1'b0 || os[c] !== 1'b0 || od[c] !== '0) begin
        n_bad++;
        $display("FAIL reset cfg%0d: got v=%b s=%b d=%h, want v=0 s=0 d=0", c, ov[c], os[c], od[c]);
      end
    end
  endtask

  task automatic test_basic_d1();
    int e0 [4] = '{0, 21, 11, 23};
    int e1 [4] = '{0, 20, 10, 22};
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      step(1'b1, n == 0, 1'b0, mk_word(10 + n, 20 + n));
      n_cmp++;
      if (n == 0 && ov[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL basic_d1 priming: got v=%b, want v=0", ov[0]);
      end else if (n > 0 && (ov[0] !== 1'b1 || os[0] !== (n == 1) || od[0] !== mk_word(e0[n], e1[n]))) begin
        n_bad++;
        $display("FAIL basic_d1 n=%0d: got v=%b s=%b d=%h, want v=1 s=%b d=%h",
                 n, ov[0], os[0], od[0], n == 1, mk_word(e0[n], e1[n]));
      end
    end
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0, 1'b0, {$urandom, $urandom});
      n_cmp++;
      if (ov[0] !== exp_v[0] || os[0] !== exp_s[0] || (exp_known[0] && od[0] !== exp_d[0])) begin
        n_bad++;
        $display("FAIL basic_stream t=%0d: got v=%b s=%b d=%h, want v=%b s=%b d=%h",
                 t, ov[0], os[0], od[0], exp_v[0], exp_s[0], exp_d[0]);
      end
    end
  endtask

  task automatic test_stall();
    int e0 [4] = '{0, 21, 11, 23};
    int e1 [4] = '{0, 20, 10, 22};
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      step(1'b1, n == 0, 1'b0, mk_word(10 + n, 20 + n));
      if (n > 0) begin
        n_cmp++;
        if (ov[0] !== 1'b1 || os[0] !== (n == 1) || od[0] !== mk_word(e0[n], e1[n])) begin
          n_bad++;
          $display("FAIL stall n=%0d: got v=%b s=%b d=%h, want v=1 s=%b d=%h",
                   n, ov[0], os[0], od[0], n == 1, mk_word(e0[n], e1[n]));
        end
      end
      if (n == 1) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b0, 1'b0, {$urandom, $urandom});
          n_cmp++;
          if (ov[0] !== 1'b0 || os[0] !== 1'b0 || od[0] !== mk_word(21, 20)) begin
            n_bad++;
            $display("FAIL stall_gap g=%0d: got v=%b s=%b d=%h, want v=0 s=0 d=%h",
                     g, ov[0], os[0], od[0], mk_word(21, 20));
          end
        end
      end
    end
  endtask

  task automatic test_depth4();
    logic [W-1:0] w;
    apply_reset();
    for (int n = 0; n < 16; n++) begin
      w = {NB'(n + 48), NB'(n + 32), NB'(n + 16), NB'(n)};
      step(1'b1, n == 0, 1'b0, w);
      n_cmp++;
      if (ov[1] !== exp_v[1] || os[1] !== exp_s[1] || (exp_known[1] && od[1] !== exp_d[1])) begin
        n_bad++;
        $display("FAIL depth4 n=%0d: got v=%b s=%b d=%h, want v=%b s=%b d=%h",
                 n, ov[1], os[1], od[1], exp_v[1], exp_s[1], exp_d[1]);
      end
      n_cmp++;
      if ((n < 4 && ov[1] !== 1'b0) || (n == 4 && (ov[1] !== 1'b1 || os[1] !== 1'b1))) begin
        n_bad++;
        $display("FAIL depth4_priming n=%0d: got v=%b s=%b, want v=%b s=%b", n, ov[1], os[1], n >= 4, n == 4);
      end
      if (n >= 4 && n <= 7) begin
        n_cmp++;
        if (od[1][NB-1:0] !== NB'(16 + n)) begin
          n_bad++;
          $display("FAIL depth4_y0 n=%0d: got %0d, want %0d", n, od[1][NB-1:0], 16 + n);
        end
      end
      if (n >= 8 && n <= 11) begin
        n_cmp++;
        if (od[1][2*NB-1:NB] !== NB'(n - 8)) begin
          n_bad++;
          $display("FAIL depth4_y1 n=%0d: got %0d, want %0d", n, od[1][2*NB-1:NB], n - 8);
        end
      end
    end
    for (int i = 0; i < 40; i++) begin
      step(($urandom % 3) != 0, 1'b0, 1'b0, {$urandom, $urandom});
      n_cmp++;
      if (ov[1] !== exp_v[1] || os[1] !== exp_s[1] || (exp_known[1] && od[1] !== exp_d[1])) begin
        n_bad++;
        $display("FAIL depth4_stall t=%0d: got v=%b s=%b d=%h, want v=%b s=%b d=%h",
                 t, ov[1], os[1], od[1], exp_v[1], exp_s[1], exp_d[1]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] xs [$];
    logic [W-1:0] w;
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      w = {$urandom, $urandom};
      if (i > 0 && ($urandom % 4) == 0) begin
        step(1'b0, 1'b0, 1'b0, w);
      end else begin
        xs.push_back(w);
        step(1'b1, i == 0, 1'b1, w);
        if (xs.size() > 2) begin
          n_cmp++;
          if (ov[2] !== 1'b1 || od[2] !== xs[xs.size() - 3]) begin
            n_bad++;
            $display("FAIL bypass n=%0d: got v=%b d=%h, want v=1 d=%h", xs.size() - 1, ov[2], od[2], xs[xs.size() - 3]);
          end
        end
      end
      n_cmp++;
      if (ov[2] !== exp_v[2] || os[2] !== exp_s[2] || (exp_known[2] && od[2] !== exp_d[2])) begin
        n_bad++;
        $display("FAIL bypass_model t=%0d: got v=%b s=%b d=%h, want v=%b s=%b d=%h",
                 t, ov[2], os[2], od[2], exp_v[2], exp_s[2], exp_d[2]);
      end
    end
  endtask

  task automatic test_restart_reset();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i == 0 || i == 5, 1'b0, {$urandom, $urandom});
      n_cmp++;
      if (ov[1] !== exp_v[1] || os[1] !== exp_s[1] || (exp_known[1] && od[1] !== exp_d[1])) begin
        n_bad++;
        $display("FAIL restart i=%0d: got v=%b s=%b d=%h, want v=%b s=%b d=%h",
                 i, ov[1], os[1], od[1], exp_v[1], exp_s[1], exp_d[1]);
      end
      if (i >= 5 && i <= 9) begin
        n_cmp++;
        if (ov[1] !== (i == 9) || os[1] !== (i == 9)) begin
          n_bad++;
          $display("FAIL restart_priming i=%0d: got v=%b s=%b, want v=%b s=%b", i, ov[1], os[1], i == 9, i == 9);
        end
      end
    end
    apply_reset();
    for (int c = 0; c < NCFG; c++) begin
      n_cmp++;
      if (ov[c] !== 1'b0 || os[c] !== 1'b0 || od[c] !== '0) begin
        n_bad++;
        $display("FAIL midframe_reset cfg%0d: got v=%b s=%b d=%h, want v=0 s=0 d=0", c, ov[c], os[c], od[c]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, {$urandom, $urandom});
      n_cmp++;
      if (ov[1] !== 1'b0 || ov[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL no_start_after_reset i=%0d: got v1=%b v0=%b, want 0 0", i, ov[1], ov[0]);
      end
    end
  endtask

  task automatic test_pairing_split();
    logic [W-1:0] w;
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      w = {$urandom, $urandom};
      if (i < 12) w = {NB'(0), w[2*NB +: NB], NB'(0), w[0 +: NB]};
      step(1'b1, i == 0, 1'b0, w);
      n_cmp++;
      if (ov[3] !== exp_v[3] || os[3] !== exp_s[3] || (exp_known[3] && od[3] !== exp_d[3])) begin
        n_bad++;
        $display("FAIL split t=%0d: got v=%b s=%b d=%h, want v=%b s=%b d=%h",
                 t, ov[3], os[3], od[3], exp_v[3], exp_s[3], exp_d[3]);
      end
      if (i > 0 && i < 12) begin
        n_cmp++;
        if (od[3][NB +: NB] !== '0 || od[3][3*NB +: NB] !== '0) begin
          n_bad++;
          $display("FAIL split_isolation i=%0d: got y1=%h y3=%h, want 0 0", i, od[3][NB +: NB], od[3][3*NB +: NB]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic v, s;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      v = (i == 0) || (($urandom % 4) != 0);
      s = (i == 0) || (($urandom % 40) == 0);
      step(v, s, ($urandom % 3) == 0, {$urandom, $urandom});
      for (int c = 0; c < NCFG; c++) begin
        n_cmp++;
        if (ov[c] !== exp_v[c] || os[c] !== exp_s[c] || (exp_known[c] && od[c] !== exp_d[c])) begin
          n_bad++;
          $display("FAIL random cfg%0d i=%0d: got v=%b s=%b d=%h, want v=%b s=%b d=%h",
                   c, i, ov[c], os[c], od[c], exp_v[c], exp_s[c], exp_d[c]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; start = 1'b0; bypass = 1'b0; in_data = '0;
    model_reset();
    test_reset();
    test_basic_d1();
    test_stall();
    test_depth4();
    test_bypass();
    test_restart_reset();
    test_pairing_split();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
